clk_div_gen: RTL and testbench

Parametrised, runtime-reconfigurable clock-divider and clock-enable generator for the fabric side of the `refclk` domain. It produces `NUM_CLOCKS` divided clock outputs with fixed phase relationships, one-cycle enable strobes, and a `locked` indication. It adds per-channel divide and phase programming, plus a settle/relock sequence on every reconfiguration. It feeds downstream blocks that need related slow rates without a second hard PLL.

---
 rtl/clk_div_gen_if.sv | 24 ++
 rtl/clk_div_gen.sv | 153 +++++++++++++++
 tb/tb_clk_div_gen.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_gen_if.sv
// clk_div_gen_if: configuration channel of clk_div_gen.
//   cfg_valid/cfg_ready : request handshake (accept = valid & ready)
//   cfg_chan            : target channel index
//   cfg_div / cfg_phase : new divide ratio D and phase offset P
//   cfg_err             : one-cycle pulse when a request is rejected
// master = requester, slave = clk_div_gen.
interface clk_div_gen_if #(
    parameter int NUM_CLOCKS = 2,
    parameter int CNT_W      = 8
);
    localparam int CHAN_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHAN_W-1:0] cfg_chan;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_phase;
    logic              cfg_err;

    modport master (output cfg_valid, cfg_chan, cfg_div, cfg_phase,
                    input  cfg_ready, cfg_err);
    modport slave  (input  cfg_valid, cfg_chan, cfg_div, cfg_phase,
                    output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_gen.sv
// clk_div_gen: runtime-reconfigurable clock divider / clock-enable generator.
//   refclk : sole clock          rst    : async reset, active high
//   cfg    : configuration port (clk_div_gen_if.slave)
//   outclk : registered divided clock per channel
//   clk_en : one-cycle strobe per channel period
//   locked : all channels running and phase-aligned
// clk_div_chan is the per-channel counter, instantiated once per channel.

// clk_div_chan: one divider channel.
//   run    : counter advances this edge (next state is LOCKED)
//   wr     : load wr_div/wr_phase into the channel registers
//   outclk / clk_en : registered from the next counter value
module clk_div_chan #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             run,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_phase,
    output logic             outclk,
    output logic             clk_en
);
    logic [CNT_W-1:0] div, phase, cnt;
    logic [CNT_W-1:0] div_n, phase_n, cnt_n;

    // wr only happens in RECONFIG and run never does, so the wrap test
    // can use the current divide value.
    always_comb begin
        div_n   = wr ? wr_div : div;
        phase_n = wr ? wr_phase : phase;
        if (!run)
            cnt_n = phase_n;
        else if (cnt == div - 1'b1)
            cnt_n = '0;
        else
            cnt_n = cnt + 1'b1;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            div    <= CNT_W'(DEFAULT_DIV);
            phase  <= '0;
            cnt    <= '0;
            outclk <= 1'b0;
            clk_en <= 1'b0;
        end else begin
            div    <= div_n;
            phase  <= phase_n;
            cnt    <= cnt_n;
            outclk <= run && (cnt_n < (div >> 1));
            clk_en <= run && (cnt_n == div - 1'b1);
        end
    end
endmodule

module clk_div_gen #(
    parameter int NUM_CLOCKS  = 2,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 5,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                  refclk,
    input  logic                  rst,
    clk_div_gen_if.slave          cfg,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] clk_en,
    output logic                  locked
);
    localparam int CHAN_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
    localparam int SET_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [1:0] SETTLE   = 2'd0;
    localparam logic [1:0] LOCKED   = 2'd1;
    localparam logic [1:0] RECONFIG = 2'd2;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic [CNT_W-1:0]  div;
        logic [CNT_W-1:0]  phase;
    } cfg_req_t;

    logic [1:0]            state, state_n;
    logic [SET_W-1:0]      settle_cnt;
    cfg_req_t              pend;
    logic                  accept, req_ok, run;
    logic [NUM_CLOCKS-1:0] wr;

    assign cfg.cfg_ready = !rst && (state != RECONFIG);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign req_ok        = (32'(cfg.cfg_chan) < NUM_CLOCKS)
                        && (cfg.cfg_div >= CNT_W'(2))
                        && (cfg.cfg_phase < cfg.cfg_div);

    // A valid accept beats settle completion, so the settle count always
    // restarts from the last accepted request.
    always_comb begin
        state_n = state;
        case (state)
            SETTLE: begin
                if (accept && req_ok)
                    state_n = RECONFIG;
                else if (settle_cnt == SET_W'(LOCK_CYCLES - 1))
                    state_n = LOCKED;
            end
            LOCKED:   if (accept && req_ok) state_n = RECONFIG;
            RECONFIG: state_n = SETTLE;
            default:  state_n = SETTLE;
        endcase
    end

    // Channels advance on the edge that enters LOCKED, so the first
    // locked cycle already shows count P+1.
    assign run = (state_n == LOCKED);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            pend       <= '0;
            locked     <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            state       <= state_n;
            settle_cnt  <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
            locked      <= (state_n == LOCKED);
            cfg.cfg_err <= accept && !req_ok;
            if (accept && req_ok)
                pend <= {cfg.cfg_chan, cfg.cfg_div, cfg.cfg_phase};
        end
    end

    // Every channel is held at its phase through RECONFIG/SETTLE and
    // released on the same edge, which keeps them aligned.
    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
        assign wr[i] = (state == RECONFIG) && (pend.chan == CHAN_W'(i));
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .refclk   (refclk),
            .rst      (rst),
            .run      (run),
            .wr       (wr[i]),
            .wr_div   (pend.div),
            .wr_phase (pend.phase),
            .outclk   (outclk[i]),
            .clk_en   (clk_en[i])
        );
    end
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: scoreboard bench for clk_div_gen.
// Two instances: dut_a (2 channels) and dut_b (3 channels, so an
// out-of-range channel index is representable). Expected values are
// queued with the refclk cycle they apply to and checked on the falling
// edge of that cycle.
module tb_clk_div_gen;
    logic refclk, rst, rst_b;
    logic [1:0] outclk_a, clk_en_a;
    logic [2:0] outclk_b, clk_en_b;
    logic locked_a, locked_b;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct packed {
        int at; int dut; int kind; int ch; logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    exp_t e_chk;

    clk_div_gen_if #(.NUM_CLOCKS(2), .CNT_W(8)) ifa ();
    clk_div_gen_if #(.NUM_CLOCKS(3), .CNT_W(8)) ifb ();

    clk_div_gen #(.NUM_CLOCKS(2), .CNT_W(8), .DEFAULT_DIV(5), .LOCK_CYCLES(16)) dut_a (
        .refclk(refclk), .rst(rst), .cfg(ifa),
        .outclk(outclk_a), .clk_en(clk_en_a), .locked(locked_a));
    clk_div_gen #(.NUM_CLOCKS(3), .CNT_W(8), .DEFAULT_DIV(5), .LOCK_CYCLES(16)) dut_b (
        .refclk(refclk), .rst(rst_b), .cfg(ifb),
        .outclk(outclk_b), .clk_en(clk_en_b), .locked(locked_b));

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic string knm(int kind);
        case (kind)
            0: return "locked";
            1: return "outclk";
            2: return "clk_en";
            3: return "cfg_err";
            default: return "cfg_ready";
        endcase
    endfunction

    function automatic logic [31:0] sig(int d, int kind, int ch);
        logic [31:0] r;
        r = '0;
        if (d == 0) begin
            case (kind)
                0: r = 32'(locked_a);
                1: r = 32'(outclk_a[ch]);
                2: r = 32'(clk_en_a[ch]);
                3: r = 32'(ifa.cfg_err);
                default: r = 32'(ifa.cfg_ready);
            endcase
        end else begin
            case (kind)
                0: r = 32'(locked_b);
                1: r = 32'(outclk_b[ch]);
                2: r = 32'(clk_en_b[ch]);
                3: r = 32'(ifb.cfg_err);
                default: r = 32'(ifb.cfg_ready);
            endcase
        end
        return r;
    endfunction

    // Sorted insert keeps the queue head the earliest pending check.
    function automatic void push(int at, int d, int kind, int ch, logic [31:0] v);
        exp_t e;
        int i;
        e = '{at: at, dut: d, kind: kind, ch: ch, val: v};
        i = sb.size();
        while (i > 0 && sb[i-1].at > at) i--;
        sb.insert(i, e);
    endfunction

    // Channel with divide D, phase P that locked on edge L: on cycle k the
    // count is (P+1+k-L) mod D.
    function automatic void push_pat(int d, int ch, int L, int D, int P, int from, int n);
        int c;
        for (int k = from; k < from + n; k++) begin
            c = (P + 1 + k - L) % D;
            push(k, d, 1, ch, (c < D / 2) ? 32'd1 : 32'd0);
            push(k, d, 2, ch, (c == D - 1) ? 32'd1 : 32'd0);
        end
    endfunction

    function automatic void expect_boot(int d, int c0);
        int nch;
        nch = (d == 0) ? 2 : 3;
        push(c0 + 1, d, 4, 0, 1);
        push(c0 + 1, d, 0, 0, 0);
        push(c0 + 15, d, 0, 0, 0);
        push(c0 + 16, d, 0, 0, 1);
        for (int ch = 0; ch < nch; ch++) begin
            push(c0 + 15, d, 1, ch, 0);
            push(c0 + 15, d, 2, ch, 0);
            push_pat(d, ch, c0 + 16, 5, 0, c0 + 16, 15);
        end
    endfunction

    always @(negedge refclk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e_chk = sb.pop_front();
            chk($sformatf("%s%0d[%0d]@%0d", knm(e_chk.kind), e_chk.dut, e_chk.ch, e_chk.at),
                sig(e_chk.dut, e_chk.kind, e_chk.ch), e_chk.val);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(negedge refclk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 0);
        sb.delete();
    endtask

    task automatic drive(int d, int chan, int dv, int ph, int hold);
        if (d == 0) begin
            ifa.cfg_valid = 1'b1; ifa.cfg_chan = 1'(chan);
            ifa.cfg_div = 8'(dv); ifa.cfg_phase = 8'(ph);
        end else begin
            ifb.cfg_valid = 1'b1; ifb.cfg_chan = 2'(chan);
            ifb.cfg_div = 8'(dv); ifb.cfg_phase = 8'(ph);
        end
        repeat (hold) @(negedge refclk);
        if (d == 0) ifa.cfg_valid = 1'b0;
        else        ifb.cfg_valid = 1'b0;
    endtask

    initial begin
        int c0, t;
        rst = 1'b1; rst_b = 1'b1;
        ifa.cfg_valid = 1'b0; ifa.cfg_chan = '0; ifa.cfg_div = '0; ifa.cfg_phase = '0;
        ifb.cfg_valid = 1'b0; ifb.cfg_chan = '0; ifb.cfg_div = '0; ifb.cfg_phase = '0;
        repeat (3) @(negedge refclk);
        chk("rst_ready_a", 32'(ifa.cfg_ready), 0);
        chk("rst_locked_a", 32'(locked_a), 0);
        chk("rst_outclk_a", 32'(outclk_a), 0);
        chk("rst_clk_en_a", 32'(clk_en_a), 0);
        chk("rst_err_a", 32'(ifa.cfg_err), 0);
        chk("rst_ready_b", 32'(ifb.cfg_ready), 0);
        chk("rst_locked_b", 32'(locked_b), 0);

        // Reset release: lock on edge 16, both channels /5 in step.
        c0 = cyc;
        rst = 1'b0; rst_b = 1'b0;
        expect_boot(0, c0);
        expect_boot(1, c0);
        drain();

        // Reconfigure ch1 of dut_a to D=4, P=2 while locked.
        @(negedge refclk);
        t = cyc + 1;
        push(t, 0, 4, 0, 0);
        push(t + 1, 0, 4, 0, 1);
        push(t, 0, 0, 0, 0);
        push(t + 16, 0, 0, 0, 0);
        push(t + 17, 0, 0, 0, 1);
        for (int ch = 0; ch < 2; ch++) begin
            push(t, 0, 1, ch, 0); push(t, 0, 2, ch, 0);
            push(t + 8, 0, 1, ch, 0); push(t + 8, 0, 2, ch, 0);
        end
        push_pat(0, 0, t + 17, 5, 0, t + 17, 12);
        push_pat(0, 1, t + 17, 4, 2, t + 17, 12);
        drive(0, 1, 4, 2, 1);
        c0 = t + 17;
        drain();

        // Invalid requests on dut_a: D=1, then P=D=6; nothing else moves.
        @(negedge refclk);
        t = cyc + 1;
        push(t, 0, 3, 0, 1); push(t + 1, 0, 3, 0, 0);
        push(t + 3, 0, 3, 0, 1); push(t + 4, 0, 3, 0, 0);
        push(t + 1, 0, 4, 0, 1);
        for (int k = t; k < t + 6; k++) push(k, 0, 0, 0, 1);
        push_pat(0, 0, c0, 5, 0, t, 8);
        push_pat(0, 1, c0, 4, 2, t, 8);
        drive(0, 0, 1, 0, 1);
        repeat (2) @(negedge refclk);
        drive(0, 1, 6, 6, 1);
        drain();

        // Back-to-back valid requests: second waits out RECONFIG.
        @(negedge refclk);
        t = cyc + 1;
        push(t, 0, 4, 0, 0);
        push(t + 1, 0, 4, 0, 1);
        push(t + 2, 0, 4, 0, 0);
        push(t, 0, 0, 0, 0);
        push(t + 18, 0, 0, 0, 0);
        push(t + 19, 0, 0, 0, 1);
        push_pat(0, 0, t + 19, 3, 1, t + 19, 12);
        push_pat(0, 1, t + 19, 6, 0, t + 19, 12);
        drive(0, 0, 3, 1, 1);
        drive(0, 1, 6, 0, 2);
        drain();

        // Short async reset mid-period: immediate clear, then defaults.
        @(posedge refclk);
        #2;
        chk("pre_rst_locked_a", 32'(locked_a), 1);
        rst = 1'b1;
        #1;
        chk("prst_outclk_a", 32'(outclk_a), 0);
        chk("prst_clk_en_a", 32'(clk_en_a), 0);
        chk("prst_locked_a", 32'(locked_a), 0);
        chk("prst_ready_a", 32'(ifa.cfg_ready), 0);
        chk("prst_locked_b", 32'(locked_b), 1);
        rst = 1'b0;
        c0 = cyc;
        expect_boot(0, c0);
        drain();

        // dut_b: channel index 3 with 3 channels is rejected.
        @(negedge refclk);
        t = cyc + 1;
        push(t, 1, 3, 0, 1); push(t + 1, 1, 3, 0, 0);
        push(t, 1, 0, 0, 1); push(t + 1, 1, 0, 0, 1);
        push(t + 1, 1, 4, 0, 1);
        drive(1, 3, 4, 0, 1);
        drain();

        // dut_b: maximum divide 255 on ch2 over three periods.
        @(negedge refclk);
        t = cyc + 1;
        push(t, 1, 0, 0, 0);
        push(t + 16, 1, 0, 0, 0);
        push(t + 17, 1, 0, 0, 1);
        push_pat(1, 2, t + 17, 255, 0, t + 17, 765);
        push_pat(1, 0, t + 17, 5, 0, t + 17, 10);
        drive(1, 2, 255, 0, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
